// File: rtl/mult32_seq_ctrl_pkg.sv
// rtl/mult32_seq_ctrl_pkg.sv - shared widths, state encoding and helpers for the sequential multiplier
package mult32_seq_ctrl_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam int ITER  = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Magnitude of a two's-complement word; the most negative value maps to itself, read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/mult32_seq_ctrl_dp.sv
// rtl/mult32_seq_ctrl_dp.sv - operand, multiplier and accumulator registers with one shift-add stage
module mult32_seq_ctrl_dp
  import mult32_seq_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               prep_i,
  input  logic               run_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q;
  logic               sgn_q, neg_q;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  always_comb begin
    pp     = mcand_q & {WIDTH{mplier_q[0]}};
    sum    = {1'b0, acc_q} + {1'b0, pp};
    raw    = {acc_q, mplier_q};
    prod_o = neg_q ? (~raw + {{(2*WIDTH-1){1'b0}}, 1'b1}) : raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      sgn_q    <= signed_i;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else if (prep_i) begin
      acc_q <= '0;
      if (sgn_q) begin
        mcand_q  <= abs_val(mcand_q);
        mplier_q <= abs_val(mplier_q);
        neg_q    <= mcand_q[WIDTH-1] ^ mplier_q[WIDTH-1];
      end
    end else if (run_i) begin
      // Carry-out and sum shift right together; the bit leaving the sum enters the multiplier top.
      acc_q    <= sum[WIDTH:1];
      mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult32_seq_ctrl.sv
// rtl/mult32_seq_ctrl.sv - sequential 32x32 signed/unsigned multiplier with start/busy/done handshake
module mult32_seq_ctrl
  import mult32_seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               load, prep, run;
  logic [2*WIDTH-1:0] prod;

  mult32_seq_ctrl_dp u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .prep_i   (prep),
    .run_i    (run),
    .a_i      (a_i),
    .b_i      (b_i),
    .signed_i (signed_i),
    .prod_o   (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    prep    = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        prep    = 1'b1;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        run   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        {hi_d, lo_d} = prod;
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign done_o = (state_q == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// tb/tb_mult32_seq_ctrl.sv - randomized self-checking bench for mult32_seq_ctrl
module tb_mult32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult32_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Launches from IDLE/DONE at posedge+1; scrambles operands after the start edge; returns at DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat);
    start_i = 1'b1; a_i = a; b_i = b; signed_i = s;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; signed_i = 1'($urandom);
    lat = 0;
    while (!done_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    hi = hi_o; lo = lo_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy_o, done_o, hi_o, lo_o} !== 66'd0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy_o, done_o, hi_o, lo_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    logic [31:0] tb [6] = '{32'd5, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
    logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] want;
    logic [31:0] hi, lo;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      want = ref_prod(ta[i], tb[i], ts[i]);
      run_op(ta[i], tb[i], ts[i], hi, lo, lat);
      n_vec++;
      if ({hi, lo} !== want) begin
        n_err++;
        $display("FAIL directed[%0d] product: got %h_%h, want %h", i, hi, lo, want);
      end
      n_vec++;
      if (lat !== 34) begin
        n_err++;
        $display("FAIL directed[%0d] latency: got %0d, want 34", i, lat);
      end
      @(posedge clk); #1;
      n_vec++;
      if (done_o !== 1'b0 || {hi_o, lo_o} !== want) begin
        n_err++;
        $display("FAIL directed[%0d] done_pulse/hold: done=%b hi=%h lo=%h, want 0 %h", i, done_o, hi_o, lo_o, want);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo;
    logic        s;
    logic [63:0] want;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i == 0) a[31] = 1'b1;
      if (i == 1) b[31] = 1'b1;
      want = ref_prod(a, b, s);
      run_op(a, b, s, hi, lo, lat);
      n_vec++;
      if ({hi, lo} !== want || lat !== 34) begin
        n_err++;
        $display("FAIL random[%0d] %h x %h s=%b: got %h_%h lat=%0d, want %h lat=34", i, a, b, s, hi, lo, lat, want);
      end
      if (i % 2 == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b, hi, lo;
    logic [63:0] want;
    int          dones;
    a = $urandom; b = $urandom;
    want = ref_prod(a, b, 1'b1);
    hi = '0; lo = '0;
    start_i = 1'b1; a_i = a; b_i = b; signed_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    dones = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5 || c == 20) begin
        start_i = 1'b1; a_i = $urandom; b_i = $urandom;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (done_o) begin
        dones++;
        hi = hi_o; lo = lo_o;
      end
    end
    n_vec++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL start_ignored count: got %0d done pulses, want 1", dones);
    end
    n_vec++;
    if ({hi, lo} !== want) begin
      n_err++;
      $display("FAIL start_ignored product: got %h_%h, want %h", hi, lo, want);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] hi, lo;
    int          lat;
    start_i = 1'b1; a_i = 32'hDEADBEEF; b_i = 32'h00012345; signed_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, done_o, hi_o, lo_o} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, want all zero", busy_o, done_o, hi_o, lo_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd7, 32'd6, 1'b0, hi, lo, lat);
    n_vec++;
    if (hi !== 32'd0 || lo !== 32'd42 || lat !== 34) begin
      n_err++;
      $display("FAIL after_abort 7x6: got %h_%h lat=%0d, want 0_0000002a lat=34", hi, lo, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, hi, lo;
    logic [63:0] w1, w2;
    int          lat;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    w1 = ref_prod(a1, b1, 1'b0);
    w2 = ref_prod(a2, b2, 1'b1);
    run_op(a1, b1, 1'b0, hi, lo, lat);
    n_vec++;
    if ({hi, lo} !== w1) begin
      n_err++;
      $display("FAIL b2b first: got %h_%h, want %h", hi, lo, w1);
    end
    start_i = 1'b1; a_i = a2; b_i = b2; signed_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b restart busy: got %b, want 1", busy_o);
    end
    lat = 0;
    while (!done_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 15) begin
        n_vec++;
        if ({hi_o, lo_o} !== w1) begin
          n_err++;
          $display("FAIL b2b hold: got %h_%h, want %h", hi_o, lo_o, w1);
        end
      end
    end
    n_vec++;
    if ({hi_o, lo_o} !== w2 || lat !== 34) begin
      n_err++;
      $display("FAIL b2b second: got %h_%h lat=%0d, want %h lat=34", hi_o, lo_o, lat, w2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
